// File: rtl/strassen_result_streamer.sv
// strassen_result_streamer
//   Captures an N x N signed result matrix when the multiplier core signals
//   done, then streams it out LANES elements per beat over valid/ready.
//   Emit order is row-major, or column-major when transpose was set at
//   capture time. out_row_last marks the end of each row (or column) and
//   out_last marks the final beat of the frame.
//
//   Optional feature macro: RESULT_CKSUM_EN
//     When defined, one extra beat follows the data beats. It carries the
//     running XOR of every data beat, with out_last=1 and out_row_last=0.
//     When undefined, the frame is exactly N*N/LANES beats and neither the
//     checksum state nor the XOR accumulator exists.
`timescale 1ns/1ps

module strassen_result_streamer #(
  parameter int N     = 16,
  parameter int DW    = 16,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*N*DW-1:0]   mat_in,
  input  logic                mat_valid,
  input  logic                transpose,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_row_last,
  output logic                out_last,
  output logic                busy,
  output logic                overflow
);

  localparam int B  = (N * N) / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef RESULT_CKSUM_EN
    CKSUM  = 2'd2,
`endif
    STREAM = 2'd1
  } state_t;

  state_t              stateQ, stateD;
  logic [BW-1:0]       beatQ, beatD;
  logic [N*N*DW-1:0]   matQ, matD;
  logic                transQ, transD;
  logic                overflowQ, overflowD;
  logic [LANES*DW-1:0] laneData;
`ifdef RESULT_CKSUM_EN
  logic [LANES*DW-1:0] xorQ, xorD;
`endif

  // Flat element index feeding a lane. The linear position e walks the
  // output order; transposed frames swap the row and column roles.
  function automatic int srcIndex(input int beat, input int lane, input logic tr);
    int e;
    int r;
    int c;
    e = beat * LANES + lane;
    r = e / N;
    c = e % N;
    return tr ? (c * N + r) : (r * N + c);
  endfunction

  // A beat closes a row (or column) when the elements it completes fill
  // an exact multiple of N.
  function automatic logic isRowEnd(input int beat);
    return (((beat + 1) * LANES) % N) == 0;
  endfunction

  // Pick the LANES elements of the current beat out of the held matrix.
  always_comb begin
    laneData = '0;
    for (int l = 0; l < LANES; l++) begin
      laneData[l*DW +: DW] = matQ[srcIndex(int'(beatQ), l, transQ)*DW +: DW];
    end
  end

  // Next-state logic and the output decode of the streaming FSM.
  always_comb begin
    stateD       = stateQ;
    beatD        = beatQ;
    matD         = matQ;
    transD       = transQ;
    overflowD    = overflowQ;
`ifdef RESULT_CKSUM_EN
    xorD         = xorQ;
`endif
    out_data     = '0;
    out_valid    = 1'b0;
    out_row_last = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;

    case (stateQ)
      IDLE: begin
        if (mat_valid) begin
          matD   = mat_in;
          transD = transpose;
          beatD  = '0;
`ifdef RESULT_CKSUM_EN
          xorD   = '0;
`endif
          stateD = STREAM;
        end
      end

      STREAM: begin
        out_valid    = 1'b1;
        busy         = 1'b1;
        out_data     = laneData;
        out_row_last = isRowEnd(int'(beatQ));
`ifndef RESULT_CKSUM_EN
        out_last     = (beatQ == LAST_BEAT);
`endif
        if (mat_valid) begin
          overflowD = 1'b1;
        end
        if (out_ready) begin
`ifdef RESULT_CKSUM_EN
          xorD = xorQ ^ laneData;
`endif
          if (beatQ == LAST_BEAT) begin
            beatD = '0;
`ifdef RESULT_CKSUM_EN
            stateD = CKSUM;
`else
            stateD = IDLE;
`endif
          end else begin
            beatD = beatQ + BW'(1);
          end
        end
      end

`ifdef RESULT_CKSUM_EN
      CKSUM: begin
        out_valid    = 1'b1;
        busy         = 1'b1;
        out_data     = xorQ;
        out_row_last = 1'b0;
        out_last     = 1'b1;
        if (mat_valid) begin
          overflowD = 1'b1;
        end
        if (out_ready) begin
          stateD = IDLE;
        end
      end
`endif

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign overflow = overflowQ;

  // State, counter, capture and sticky-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      beatQ     <= '0;
      matQ      <= '0;
      transQ    <= 1'b0;
      overflowQ <= 1'b0;
`ifdef RESULT_CKSUM_EN
      xorQ      <= '0;
`endif
    end else begin
      stateQ    <= stateD;
      beatQ     <= beatD;
      matQ      <= matD;
      transQ    <= transD;
      overflowQ <= overflowD;
`ifdef RESULT_CKSUM_EN
      xorQ      <= xorD;
`endif
    end
  end

endmodule

// File: tb/tb_strassen_result_streamer.sv
// tb_strassen_result_streamer
//   Drives directed and randomized frames into strassen_result_streamer and
//   compares every output on every cycle against a queue-based model that
//   holds the beats the sink should see. Honours RESULT_CKSUM_EN.
`timescale 1ns/1ps

module tb_strassen_result_streamer;

  localparam int N     = 16;
  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int B     = (N * N) / LANES;
  localparam int CW    = LANES * DW;
`ifdef RESULT_CKSUM_EN
  localparam int FRAME_BEATS = B + 1;
`else
  localparam int FRAME_BEATS = B;
`endif

  typedef struct packed {
    logic [CW-1:0] data;
    logic          rowLast;
    logic          last;
  } beat_t;

  logic              clk;
  logic              rst;
  logic [N*N*DW-1:0] matIn;
  logic              mat_valid;
  logic              transpose;
  logic [CW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_row_last;
  logic              out_last;
  logic              busy;
  logic              overflow;

  logic [DW-1:0] stimMat [N*N];
  beat_t         expQ [$];
  logic          mOverflow;
  int            frameHs;
  int            checkCount;
  int            passCount;
  logic [3:0]    readyPattern;

  beat_t         curExp;
  logic          expValid;
  logic [CW-1:0] ckAcc;

  strassen_result_streamer #(.N(N), .DW(DW), .LANES(LANES)) dut (
    .clk          (clk),
    .rst          (rst),
    .mat_in       (matIn),
    .mat_valid    (mat_valid),
    .transpose    (transpose),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flatten the stimulus matrix onto the capture bus.
  always_comb begin
    matIn = '0;
    for (int i = 0; i < N * N; i++) begin
      matIn[i*DW +: DW] = stimMat[i];
    end
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                             input logic [CW-1:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Hold the given inputs for exactly one rising edge; returns 1 ns after it.
  task automatic applyStimulus(input logic r, input logic mv, input logic tr, input logic rdy);
    rst       = r;
    mat_valid = mv;
    transpose = tr;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Beat k of a frame straight from the emit-order rule: lane l carries
  // linear position e = k*LANES + l, read row-major or column-major.
  function automatic beat_t getBeat(input int k, input logic tr);
    beat_t b;
    int    e;
    int    row;
    int    col;
    b.data = '0;
    for (int l = 0; l < LANES; l++) begin
      e = k * LANES + l;
      if (tr) begin
        row = e % N;
        col = e / N;
      end else begin
        row = e / N;
        col = e % N;
      end
      b.data[l*DW +: DW] = stimMat[row * N + col];
    end
    b.rowLast = (((k + 1) * LANES) % N) == 0;
`ifdef RESULT_CKSUM_EN
    b.last = 1'b0;
`else
    b.last = (k == B - 1);
`endif
    return b;
  endfunction

  task automatic loadCounting();
    for (int i = 0; i < N * N; i++) stimMat[i] = DW'(i);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < N * N; i++) stimMat[i] = DW'($urandom);
  endtask

  // Compare every output mid-cycle, then advance the model using the
  // inputs the DUT is about to sample on the next rising edge.
  initial begin
    mOverflow = 1'b0;
    frameHs   = 0;
    forever begin
      @(negedge clk);
      expValid = (expQ.size() != 0);
      curExp   = expValid ? expQ[0] : '0;
      checkOutput("out_valid", CW'(out_valid), CW'(expValid));
      checkOutput("busy", CW'(busy), CW'(expValid));
      checkOutput("overflow", CW'(overflow), CW'(mOverflow));
      checkOutput("out_data", out_data, curExp.data);
      checkOutput("out_row_last", CW'(out_row_last), CW'(curExp.rowLast));
      checkOutput("out_last", CW'(out_last), CW'(curExp.last));
      if (rst) begin
        expQ.delete();
        mOverflow = 1'b0;
      end else begin
        if (mat_valid) begin
          if (expValid) begin
            mOverflow = 1'b1;
          end else begin
            frameHs = 0;
            ckAcc   = '0;
            for (int k = 0; k < B; k++) begin
              expQ.push_back(getBeat(k, transpose));
              ckAcc ^= getBeat(k, transpose).data;
            end
`ifdef RESULT_CKSUM_EN
            expQ.push_back('{data: ckAcc, rowLast: 1'b0, last: 1'b1});
`endif
          end
        end
        if (expValid && out_ready) begin
          void'(expQ.pop_front());
          frameHs++;
        end
      end
    end
  end

  task automatic startFrame(input logic tr);
    applyStimulus(1'b0, 1'b1, tr, 1'b1);
  endtask

  // Drain the current frame. mode 0: always ready, 1: 1,0,0,1 pattern,
  // otherwise random ready. randomPulse injects capture strobes with fresh data.
  task automatic runUntilIdle(input int mode, input bit randomPulse);
    int   cyc;
    logic rdy;
    logic mv;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 4000) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = readyPattern[cyc % 4];
      else                rdy = ($urandom_range(0, 3) != 0);
      mv = 1'b0;
      if (randomPulse && $urandom_range(0, 19) == 0) begin
        mv = 1'b1;
        loadRandom();
      end
      applyStimulus(1'b0, mv, 1'b0, rdy);
      cyc++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drainTimeout: %0d beats still pending after %0d cycles", expQ.size(), cyc);
    end
  endtask

  task automatic advanceToBeat(input int target);
    int cyc;
    cyc = 0;
    while (frameHs < target && cyc < 1000) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      cyc++;
    end
    if (frameHs < target) begin
      checkCount++;
      $display("[TB] FAIL beatTimeout: reached %0d, required %0d", frameHs, target);
    end
  endtask

  // Main sequence.
  initial begin
    beat_t b;
    checkCount   = 0;
    passCount    = 0;
    readyPattern = 4'b1001;
    rst          = 1'b1;
    mat_valid    = 1'b0;
    transpose    = 1'b0;
    out_ready    = 1'b0;
    loadCounting();

    // Reset held for three cycles.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstValid", CW'(out_valid), '0);
    checkOutput("rstBusy", CW'(busy), '0);
    checkOutput("rstOverflow", CW'(overflow), '0);
    checkOutput("rstLast", CW'(out_last), '0);
    checkOutput("rstRowLast", CW'(out_row_last), '0);
    checkOutput("rstData", out_data, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Hand-computed beats for the counting matrix pin the model.
    b = getBeat(0, 1'b0);
    checkOutput("litRow0", b.data, {16'd3, 16'd2, 16'd1, 16'd0});
    b = getBeat(3, 1'b0);
    checkOutput("litRow3RowLast", CW'(b.rowLast), CW'(1));
    b = getBeat(2, 1'b0);
    checkOutput("litRow2RowLast", CW'(b.rowLast), CW'(0));
    b = getBeat(63, 1'b0);
    checkOutput("litRow63", b.data, {16'd255, 16'd254, 16'd253, 16'd252});
`ifdef RESULT_CKSUM_EN
    checkOutput("litRow63Last", CW'(b.last), CW'(0));
`else
    checkOutput("litRow63Last", CW'(b.last), CW'(1));
`endif
    b = getBeat(0, 1'b1);
    checkOutput("litTr0", b.data, {16'd48, 16'd32, 16'd16, 16'd0});
    b = getBeat(3, 1'b1);
    checkOutput("litTr3", b.data, {16'd240, 16'd224, 16'd208, 16'd192});
    checkOutput("litTr3RowLast", CW'(b.rowLast), CW'(1));
    b = getBeat(60, 1'b1);
    checkOutput("litTr60", b.data, {16'd63, 16'd47, 16'd31, 16'd15});
    b = getBeat(63, 1'b1);
    checkOutput("litTr63", b.data, {16'd255, 16'd239, 16'd223, 16'd207});

    // Row-major frame, sink always ready.
    startFrame(1'b0);
    runUntilIdle(0, 1'b0);
    checkOutput("hsRowMajor", CW'(frameHs), CW'(FRAME_BEATS));

    // Transposed frame, back to back after the one idle cycle.
    startFrame(1'b1);
    runUntilIdle(0, 1'b0);
    checkOutput("hsTransposed", CW'(frameHs), CW'(FRAME_BEATS));

    // Backpressure with ready toggling 1,0,0,1.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    startFrame(1'b0);
    runUntilIdle(1, 1'b0);
    checkOutput("hsBackpressure", CW'(frameHs), CW'(FRAME_BEATS));

    // Capture strobe mid-frame with a different matrix is dropped.
    startFrame(1'b0);
    advanceToBeat(20);
    loadRandom();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    runUntilIdle(0, 1'b0);
    checkOutput("overflowSticky", CW'(overflow), CW'(1));
    checkOutput("hsAfterDrop", CW'(frameHs), CW'(FRAME_BEATS));

    // Reset in the middle of a new frame abandons it.
    loadCounting();
    startFrame(1'b0);
    advanceToBeat(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("midRstValid", CW'(out_valid), '0);
    checkOutput("midRstBusy", CW'(busy), '0);
    checkOutput("midRstOverflow", CW'(overflow), '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized frames, random ready, stray capture strobes.
    for (int f = 0; f < 8; f++) begin
      loadRandom();
      startFrame(1'($urandom_range(0, 1)));
      runUntilIdle(2, 1'b1);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
